cache_controller: RTL

//  Sits between the MEM stage and the SRAM controller. Fronts the 2-way, 64-set, 64-bit-line data cache.

---
 rtl/cache_controller_pkg.sv | 24 ++
 rtl/cache_controller.sv | 117 +++++++++++
 2 files changed

// File: rtl/cache_controller_pkg.sv
// rtl/cache_controller_pkg.sv - shared state encodings, address fields and base address for cache_controller
package cache_controller_pkg;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_RD_WAIT = 2'd1;
   localparam logic [1:0] ST_FILL    = 2'd2;
   localparam logic [1:0] ST_WR_WAIT = 2'd3;

   localparam logic [31:0] CC_BASE_ADDR = 32'd1024;

   localparam int TAG_W   = 10;
   localparam int IDX_W   = 6;
   localparam int OFF_W   = 1;
   localparam int CADDR_W = TAG_W + IDX_W + OFF_W;

   // Word address relative to data memory base; wraps modulo 2^32 with no range check.
   function automatic logic [CADDR_W-1:0] cache_addr_of(input logic [31:0] addr,
                                                        input logic [31:0] base);
      logic [31:0] rel;
      rel = addr - base;
      return rel[CADDR_W+1:2];
   endfunction

endpackage

// File: rtl/cache_controller.sv
// rtl/cache_controller.sv - write-through, read-allocate controller between MEM stage, data cache and SRAM
module cache_controller
   import cache_controller_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = CC_BASE_ADDR
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                mem_rd_en,
   input  logic                mem_wr_en,
   input  logic [31:0]         mem_addr,
   input  logic [31:0]         mem_wdata,
   output logic [31:0]         rdata,
   output logic                ready,
   output logic [CADDR_W-1:0]  cache_address,
   output logic [63:0]         cache_wdata,
   output logic                cache_rd_en,
   output logic                cache_wr_en,
   output logic                cache_is_str,
   input  logic [31:0]         cache_rdata,
   input  logic                cache_hit,
   output logic [31:0]         sram_addr,
   output logic [31:0]         sram_wdata,
   output logic                sram_rd_en,
   output logic                sram_wr_en,
   input  logic [63:0]         sram_rdata,
   input  logic                sram_ready
);

   logic [1:0]         state;
   logic [63:0]        line_q;
   logic [31:0]        addr_q;
   logic [31:0]        wdata_q;
   logic [CADDR_W-1:0] caddr_now;
   logic [CADDR_W-1:0] caddr_q;

   assign caddr_now = cache_addr_of(mem_addr, BASE_ADDR);
   assign caddr_q   = cache_addr_of(addr_q, BASE_ADDR);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= ST_IDLE;
         line_q  <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               // A simultaneous load is dropped: the store owns the access.
               if (mem_wr_en) begin
                  addr_q  <= mem_addr;
                  wdata_q <= mem_wdata;
                  state   <= ST_WR_WAIT;
               end else if (mem_rd_en && !cache_hit) begin
                  addr_q <= mem_addr;
                  state  <= ST_RD_WAIT;
               end
            end
            ST_RD_WAIT: begin
               if (sram_ready) begin
                  line_q <= sram_rdata;
                  state  <= ST_FILL;
               end
            end
            ST_FILL: state <= ST_IDLE;
            ST_WR_WAIT: begin
               if (sram_ready) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   always_comb begin
      rdata         = '0;
      ready         = 1'b1;
      cache_address = caddr_q;
      cache_wdata   = line_q;
      cache_rd_en   = 1'b0;
      cache_wr_en   = 1'b0;
      cache_is_str  = 1'b0;
      sram_addr     = '0;
      sram_wdata    = '0;
      sram_rd_en    = 1'b0;
      sram_wr_en    = 1'b0;
      case (state)
         ST_IDLE: begin
            cache_address = caddr_now;
            cache_rd_en   = mem_rd_en;
            if (mem_wr_en) begin
               cache_is_str = 1'b1;
               ready        = 1'b0;
            end else if (mem_rd_en) begin
               if (cache_hit) rdata = cache_rdata;
               else           ready = 1'b0;
            end
         end
         ST_RD_WAIT: begin
            ready      = 1'b0;
            sram_rd_en = 1'b1;
            sram_addr  = {addr_q[31:3], 3'b000};
         end
         ST_FILL: begin
            cache_wr_en = 1'b1;
            rdata       = caddr_q[0] ? line_q[63:32] : line_q[31:0];
         end
         ST_WR_WAIT: begin
            ready      = sram_ready;
            sram_wr_en = 1'b1;
            sram_addr  = addr_q;
            sram_wdata = wdata_q;
         end
         default: ready = 1'b1;
      endcase
   end

endmodule
